// File: rtl/qtrn_pkg.sv
// qtrn_pkg: shared definitions for the QTR-RC reflectance sensor peripheral.
//   - FSM state encoding (IDLE / CHARGE / SENSE)
//   - register address map and reset values
//   - ctrl register bit positions
//   - helper that maps a programmed timeout of 0 to the effective value 1
// Utility pulse array indices (only defined here if the system has not already).
`ifndef MXCLK
`define MXCLK 1
`endif
`ifndef U10CLK
`define U10CLK 0
`endif
`ifndef M10CLK
`define M10CLK 1
`endif

package qtrn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHARGE = 2'd1,
    ST_SENSE  = 2'd2
  } state_e;

  localparam logic [7:0] ADDR_MASK_LO = 8'd0;
  localparam logic [7:0] ADDR_MASK_HI = 8'd1;
  localparam logic [7:0] ADDR_THRESH  = 8'd2;
  localparam logic [7:0] ADDR_TIMEOUT = 8'd3;
  localparam logic [7:0] ADDR_PERIOD  = 8'd4;
  localparam logic [7:0] ADDR_CTRL    = 8'd5;
  localparam logic [7:0] ADDR_COUNT0  = 8'd8;

  localparam int CTRL_COUNTMODE = 0;
  localparam int CTRL_ONCHANGE  = 1;

  localparam logic [7:0] THRESH_RST  = 8'h40;
  localparam logic [7:0] TIMEOUT_RST = 8'hFF;

  // A programmed timeout of zero would end a scan before any tick; treat it as one tick.
  function automatic logic [7:0] eff_timeout(input logic [7:0] tmo);
    return (tmo == 8'd0) ? 8'd1 : tmo;
  endfunction

endpackage

// File: rtl/qtrn_chan.sv
// qtrn_chan: one sensor channel's discharge timer.
//   clk_i      system clock
//   rst_i      synchronous active-high reset (count cleared)
//   start_i    scan start: clears the done flag
//   tick_i     current (already incremented) tick value
//   tick_en_i  a 10us tick happens this cycle while sensing
//   finish_i   scan ends this cycle; an unfinished channel takes timeout_i
//   timeout_i  effective timeout used as the fill value
//   pin_i      raw sensor line (asynchronous)
//   count_o    captured discharge time in ticks
//   done_o     channel has discharged (or been filled) in this scan
module qtrn_chan #(
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] tick_i,
  input  logic          tick_en_i,
  input  logic          finish_i,
  input  logic [CW-1:0] timeout_i,
  input  logic          pin_i,
  output logic [CW-1:0] count_o,
  output logic          done_o
);

  logic          sync1_q, sync2_q;
  logic          done_q, done_d;
  logic [CW-1:0] count_q, count_d;
  logic          hit_s;

  // Two-flop synchroniser for the asynchronous sensor line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  assign hit_s = tick_en_i & ~done_q & ~sync2_q;

  // Capture the tick on first low sample; a channel still high at scan end gets the timeout
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    if (start_i) begin
      done_d = 1'b0;
    end else if (hit_s) begin
      count_d = tick_i;
      done_d  = 1'b1;
    end else if (finish_i && !done_q) begin
      count_d = timeout_i;
      done_d  = 1'b1;
    end else begin
      count_d = count_q;
      done_d  = done_q;
    end
  end

  // Count and done registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q;

endmodule

// File: rtl/qtrn.sv
// qtrn: N-channel QTR-RC reflectance sensor peripheral.
//   CLK_I/RST_I   clock, synchronous active-high reset
//   STB_I/ADR_I   select and register address; addressed when ADR_I[7:5]==0
//   TGA_I/WE_I    1=register access (WE_I: 1=write), 0=poll for pending data
//   DAT_I/DAT_O   data; DAT_O passes DAT_I through when not addressed
//   ACK_O         combinational acknowledge (=addressed); STALL_O always 0
//   clocks        utility pulse array: `U10CLK (10us) and `M10CLK (10ms) used
//   pins          sensor lines: driven high while charging, tri-stated otherwise
`ifndef MXCLK
`define MXCLK 1
`endif
`ifndef U10CLK
`define U10CLK 0
`endif
`ifndef M10CLK
`define M10CLK 1
`endif

module qtrn
  import qtrn_pkg::*;
#(
  parameter int NCH = 8,
  parameter int CW  = 8
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  input  logic           WE_I,
  input  logic           TGA_I,
  input  logic           STB_I,
  input  logic [7:0]     ADR_I,
  output logic           STALL_O,
  output logic           ACK_O,
  input  logic [7:0]     DAT_I,
  output logic [7:0]     DAT_O,
  input  logic [`MXCLK:0] clocks,
  inout  wire  [NCH-1:0] pins
);

  state_e        state_q, state_d;
  logic [3:0]    pollcnt_q, pollcnt_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [7:0]    thr_q, thr_d, tmo_q, tmo_d;
  logic [3:0]    period_q, period_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [15:0]   mask_q, mask_d, last_mask_q, last_mask_d, mask_new_s;
  logic          avail_q, avail_d, complete_q;

  logic          m10_s, u10_s, myaddr_s, wr_s, rd_s;
  logic          start_s, tick_en_s, finish_s;
  logic [CW-1:0] tick_inc_s, tmo_eff_s;
  logic [7:0]    rd_data_s, poll_reply_s;
  logic [NCH-1:0] done_s;
  logic [CW-1:0] count_s [NCH];

  assign m10_s    = clocks[`M10CLK];
  assign u10_s    = clocks[`U10CLK];
  assign myaddr_s = STB_I & (ADR_I[7:5] == 3'd0);
  assign wr_s     = TGA_I & myaddr_s & WE_I;
  assign rd_s     = TGA_I & myaddr_s & ~WE_I;

  assign tmo_eff_s  = eff_timeout(tmo_q);
  assign tick_inc_s = (tick_q == 8'hFF) ? 8'hFF : tick_q + 8'd1;
  assign start_s    = (state_q == ST_CHARGE) & u10_s;
  assign tick_en_s  = (state_q == ST_SENSE) & u10_s;
  // >= so that a timeout lowered below the running tick still ends the scan
  assign finish_s   = (state_q == ST_SENSE) &
                      ((&done_s) | (tick_en_s & (tick_inc_s >= tmo_eff_s)));

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    assign pins[ch] = (state_q == ST_CHARGE) ? 1'b1 : 1'bz;

    qtrn_chan #(.CW(CW)) u_chan (
      .clk_i    (CLK_I),
      .rst_i    (RST_I),
      .start_i  (start_s),
      .tick_i   (tick_inc_s),
      .tick_en_i(tick_en_s),
      .finish_i (finish_s),
      .timeout_i(tmo_eff_s),
      .pin_i    (pins[ch]),
      .count_o  (count_s[ch]),
      .done_o   (done_s[ch])
    );
  end

  // Scan FSM and poll-period counter
  always_comb begin
    state_d   = state_q;
    pollcnt_d = pollcnt_q;
    tick_d    = tick_q;
    case (state_q)
      ST_IDLE: begin
        if (m10_s) begin
          if (period_q == 4'd0) begin
            pollcnt_d = 4'd1;
          end else if (pollcnt_q == period_q) begin
            state_d   = ST_CHARGE;
            pollcnt_d = 4'd1;
          end else begin
            pollcnt_d = pollcnt_q + 4'd1;
          end
        end else begin
          pollcnt_d = pollcnt_q;
        end
      end
      ST_CHARGE: begin
        if (u10_s) begin
          state_d = ST_SENSE;
          tick_d  = '0;
        end else begin
          state_d = ST_CHARGE;
        end
      end
      ST_SENSE: begin
        if (tick_en_s) begin
          tick_d = tick_inc_s;
        end else begin
          tick_d = tick_q;
        end
        if (finish_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SENSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Thresholded mask from the final counts (counts settle the cycle after finish)
  always_comb begin
    mask_new_s = 16'd0;
    for (int ch = 0; ch < NCH; ch++) begin
      mask_new_s[ch] = (count_s[ch] >= thr_q);
    end
  end

  // Register writes, result latching and data-available flag
  always_comb begin
    thr_d       = thr_q;
    tmo_d       = tmo_q;
    period_d    = period_q;
    ctrl_d      = ctrl_q;
    mask_d      = mask_q;
    last_mask_d = last_mask_q;
    if (wr_s) begin
      case (ADR_I)
        ADDR_THRESH:  thr_d    = DAT_I;
        ADDR_TIMEOUT: tmo_d    = DAT_I;
        ADDR_PERIOD:  period_d = DAT_I[3:0];
        ADDR_CTRL:    ctrl_d   = DAT_I[1:0];
        default:      thr_d    = thr_q;
      endcase
    end else begin
      thr_d = thr_q;
    end
    if (complete_q) begin
      mask_d      = mask_new_s;
      last_mask_d = mask_new_s;
    end else begin
      mask_d = mask_q;
    end
    // A completion that sets the flag beats a simultaneous clearing read
    if (complete_q && (!ctrl_q[CTRL_ONCHANGE] || (mask_new_s != last_mask_q))) begin
      avail_d = 1'b1;
    end else if (rd_s) begin
      avail_d = 1'b0;
    end else begin
      avail_d = avail_q;
    end
  end

  // State and register file
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= ST_IDLE;
      pollcnt_q   <= 4'd1;
      tick_q      <= '0;
      thr_q       <= THRESH_RST;
      tmo_q       <= TIMEOUT_RST;
      period_q    <= 4'd0;
      ctrl_q      <= 2'd0;
      mask_q      <= 16'd0;
      last_mask_q <= 16'd0;
      avail_q     <= 1'b0;
      complete_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pollcnt_q   <= pollcnt_d;
      tick_q      <= tick_d;
      thr_q       <= thr_d;
      tmo_q       <= tmo_d;
      period_q    <= period_d;
      ctrl_q      <= ctrl_d;
      mask_q      <= mask_d;
      last_mask_q <= last_mask_d;
      avail_q     <= avail_d;
      complete_q  <= finish_s;
    end
  end

  // Register read mux
  always_comb begin
    case (ADR_I)
      ADDR_MASK_LO: rd_data_s = mask_q[7:0];
      ADDR_MASK_HI: rd_data_s = mask_q[15:8];
      ADDR_THRESH:  rd_data_s = thr_q;
      ADDR_TIMEOUT: rd_data_s = tmo_q;
      ADDR_PERIOD:  rd_data_s = {4'd0, period_q};
      ADDR_CTRL:    rd_data_s = {6'd0, ctrl_q};
      default:      rd_data_s = 8'd0;
    endcase
    for (int ch = 0; ch < NCH; ch++) begin
      if (ADR_I == (ADDR_COUNT0 + 8'(ch))) begin
        rd_data_s = count_s[ch];
      end
    end
  end

  // Poll reply: number of bytes the host should fetch
  always_comb begin
    if (!avail_q) begin
      poll_reply_s = 8'd0;
    end else if (ctrl_q[CTRL_COUNTMODE]) begin
      poll_reply_s = 8'(NCH);
    end else begin
      poll_reply_s = (NCH <= 8) ? 8'd1 : 8'd2;
    end
  end

  assign STALL_O = 1'b0;
  assign ACK_O   = myaddr_s;
  assign DAT_O   = !myaddr_s ? DAT_I : (TGA_I ? rd_data_s : poll_reply_s);

endmodule
